// File: rtl/fetch_seq.sv
// fetch_seq: sequential instruction-fetch address generator for a synchronous ROM.
// Latency: the word issued on rom_addr in cycle N appears on inst_data/inst_pc/inst_valid in cycle N+1.
// Backpressure: a stall with a live instruction re-reads the same word so the output stays stable.
//
// Ports:
//   clock, reset                   - single rising-edge clock, asynchronous active-high reset
//   stall                          - consumer does not accept the presented instruction this cycle
//   redirect_valid, redirect_pc    - load a new fetch PC (low two bits forced to zero)
//   halt_req, resume_req           - stop / restart fetching (halt wins when both are asserted)
//   rom_addr, rom_data             - ROM address out, ROM word in one cycle later
//   inst_data, inst_pc, inst_valid - instruction presented to the consumer
//   halted                         - sequencer is in the HALT state
//   fetch_count, stall_count       - saturating performance counters
//
// Build option: define FETCH_SEQ_PERF_EN to build the performance counters;
// without it both counter outputs are tied to zero.

module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic [31:0] rom_data,
  output logic [31:0] rom_addr,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;   // next address to issue
  logic [31:0] r_ipc;  // address of the word on inst_data
  logic        r_vld;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_ipc_nxt;
  logic        w_vld_nxt;
  logic [31:0] w_redirect_pc;
  logic        w_hold;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  // A stall only matters while a live instruction is being presented.
  assign w_hold = stall && r_vld;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_ipc   <= 32'h0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ipc   <= w_ipc_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  // Next-state logic: redirect > halt/resume > stall > advance
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ipc_nxt   = r_ipc;
    w_vld_nxt   = r_vld;
    if (redirect_valid) begin
      w_pc_nxt  = w_redirect_pc;
      w_vld_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt_req) begin
            w_state_nxt = ST_HALT;
            w_vld_nxt   = 1'b0;
            // An un-accepted instruction must be fetched again after resume.
            if (w_hold) begin
              w_pc_nxt = r_ipc;
            end
          end else if (!w_hold) begin
            w_ipc_nxt = r_pc;
            w_pc_nxt  = r_pc + 32'd4;
            w_vld_nxt = 1'b1;
          end
        end
        ST_HALT: begin
          // The first RUN cycle after resume only issues; nothing is valid yet.
          if (resume_req && !halt_req) begin
            w_state_nxt = ST_RUN;
          end
          w_vld_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    rom_addr   = r_pc;
    if (r_state == ST_RUN && w_hold) begin
      // Re-read the stalled word so rom_data stays constant next cycle.
      rom_addr = r_ipc;
    end
    inst_data  = rom_data;
    inst_pc    = r_ipc;
    inst_valid = r_vld;
    halted     = (r_state == ST_HALT);
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else if (r_vld) begin
      if (!stall && r_fetch_cnt != 32'hFFFF_FFFF) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (stall && r_stall_cnt != 32'hFFFF_FFFF) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] ROM_K  = 32'h5A5A_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        resume_req = 1'b0;
  logic [31:0] rom_data = 32'h0;
  logic [31:0] rom_addr;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_seq #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume_req(resume_req), .rom_data(rom_data),
    .rom_addr(rom_addr), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .halted(halted),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // Synchronous ROM model: word = address ^ ROM_K, one cycle latency.
  always @(posedge clock) rom_data <= rom_addr ^ ROM_K;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (rom_addr !== RST_PC) begin n_fail++; $display("FAIL rst_rom_addr: got %h want %h", rom_addr, RST_PC); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h want %h", inst_pc, 32'h0); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin n_fail++; $display("FAIL rst_counters: got %h/%h want 0/0", fetch_count, stall_count); end
    reset = 1'b0;
    #1;
    n_checks++; if (rom_addr !== RST_PC || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rel_cycle1: got addr %h vld %b want %h 0", rom_addr, inst_valid, RST_PC); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin n_fail++; $display("FAIL rel_cycle2_inst: got vld %b pc %h want 1 %h", inst_valid, inst_pc, RST_PC); end
    n_checks++; if (rom_addr !== 32'h0040_0004) begin n_fail++; $display("FAIL rel_cycle2_addr: got %h want %h", rom_addr, 32'h0040_0004); end
    n_checks++; if (inst_data !== (RST_PC ^ ROM_K)) begin n_fail++; $display("FAIL rel_cycle2_data: got %h want %h", inst_data, RST_PC ^ ROM_K); end
  endtask

  task automatic test_stall;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++; if (inst_pc !== 32'h8 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_setup: got pc %h vld %b want 8 1", inst_pc, inst_valid); end
    stall = 1'b1;
    #1;
    n_checks++; if (rom_addr !== 32'h8) begin n_fail++; $display("FAIL stall_reread_addr: got %h want %h", rom_addr, 32'h8); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (inst_pc !== 32'h8 || inst_valid !== 1'b1 || rom_addr !== 32'h8) begin n_fail++; $display("FAIL stall_hold[%0d]: got pc %h vld %b addr %h want 8 1 8", i, inst_pc, inst_valid, rom_addr); end
      n_checks++; if (inst_data !== (32'h8 ^ ROM_K)) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, inst_data, 32'h8 ^ ROM_K); end
    end
    stall = 1'b0;
    #1;
    n_checks++; if (rom_addr !== 32'hC) begin n_fail++; $display("FAIL stall_release_addr: got %h want %h", rom_addr, 32'hC); end
    tick();
    n_checks++; if (inst_pc !== 32'hC || inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_next: got pc %h vld %b want c 1", inst_pc, inst_valid); end
  endtask

  task automatic test_redirect;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (rom_addr !== 32'h100 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_first: got addr %h vld %b want 100 0", rom_addr, inst_valid); end
    tick();
    n_checks++; if (inst_pc !== 32'h100 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL redir_target: got pc %h vld %b want 100 1", inst_pc, inst_valid); end
    n_checks++; if (inst_data !== (32'h100 ^ ROM_K)) begin n_fail++; $display("FAIL redir_data: got %h want %h", inst_data, 32'h100 ^ ROM_K); end
    stall = 1'b0;
    // resume_req while running is ignored: plain advance.
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    n_checks++; if (inst_pc !== 32'h104 || halted !== 1'b0) begin n_fail++; $display("FAIL resume_in_run: got pc %h halted %b want 104 0", inst_pc, halted); end
  endtask

  task automatic test_halt;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
    tick();
    redirect_valid = 1'b0;
    tick();
    stall = 1'b1; halt_req = 1'b1;
    tick();
    stall = 1'b0; halt_req = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b1 || inst_valid !== 1'b0 || rom_addr !== 32'h20) begin n_fail++; $display("FAIL halt_enter: got h %b vld %b addr %h want 1 0 20", halted, inst_valid, rom_addr); end
    tick();
    n_checks++; if (halted !== 1'b1 || inst_valid !== 1'b0 || rom_addr !== 32'h20) begin n_fail++; $display("FAIL halt_stay: got h %b vld %b addr %h want 1 0 20", halted, inst_valid, rom_addr); end
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    n_checks++; if (halted !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== 32'h20) begin n_fail++; $display("FAIL resume_first: got h %b vld %b addr %h want 0 0 20", halted, inst_valid, rom_addr); end
    tick();
    n_checks++; if (inst_pc !== 32'h20 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL resume_refetch: got pc %h vld %b want 20 1", inst_pc, inst_valid); end
    // Halt without stall keeps the next (not yet issued) address; halt+resume together acts as halt.
    halt_req = 1'b1; resume_req = 1'b1;
    tick();
    halt_req = 1'b0; resume_req = 1'b0;
    n_checks++; if (halted !== 1'b1 || rom_addr !== 32'h24) begin n_fail++; $display("FAIL halt_nostall: got h %b addr %h want 1 24", halted, rom_addr); end
    // Redirect while halted moves the PC but stays halted.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (halted !== 1'b1 || rom_addr !== 32'h40 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_redirect: got h %b addr %h vld %b want 1 40 0", halted, rom_addr, inst_valid); end
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    tick();
    n_checks++; if (inst_pc !== 32'h40 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL halt_redirect_resume: got pc %h vld %b want 40 1", inst_pc, inst_valid); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFFC; exp_pc[1] = 32'h0000_0000; exp_pc[2] = 32'h0000_0004;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (inst_pc !== exp_pc[i] || inst_valid !== 1'b1) begin n_fail++; $display("FAIL wrap[%0d]: got pc %h vld %b want %h 1", i, inst_pc, inst_valid, exp_pc[i]); end
    end
  endtask

  task automatic test_reset_mid;
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; halt_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (rom_addr !== RST_PC || inst_valid !== 1'b0 || inst_pc !== 32'h0 || halted !== 1'b0) begin n_fail++; $display("FAIL async_reset: got addr %h vld %b pc %h h %b want %h 0 0 0", rom_addr, inst_valid, inst_pc, halted, RST_PC); end
    tick();
    redirect_valid = 1'b0; halt_req = 1'b0;
    reset = 1'b0;
    tick();
    // stall is still high but nothing was valid, so the first fetch proceeds.
    n_checks++; if (inst_pc !== RST_PC || inst_valid !== 1'b1 || halted !== 1'b0 || rom_addr !== RST_PC) begin n_fail++; $display("FAIL reset_release: got pc %h vld %b h %b addr %h want %h 1 0 %h", inst_pc, inst_valid, halted, rom_addr, RST_PC, RST_PC); end
    stall = 1'b0;
  endtask

  task automatic test_perf;
    logic [31:0] exp_f;
    logic [31:0] exp_s;
    logic        stall_pat [6];
`ifdef FETCH_SEQ_PERF_EN
    exp_f = 32'd5; exp_s = 32'd2;
`else
    exp_f = 32'd0; exp_s = 32'd0;
`endif
    stall_pat[0] = 1'b0; stall_pat[1] = 1'b0; stall_pat[2] = 1'b0;
    stall_pat[3] = 1'b1; stall_pat[4] = 1'b1; stall_pat[5] = 1'b0;
    reset = 1'b1; stall = 1'b0;
    tick();
    reset = 1'b0;
    tick();  // first instruction becomes valid; nothing counted yet
    for (int i = 0; i < 6; i++) begin
      stall = stall_pat[i];
      tick();
    end
    stall = 1'b0; halt_req = 1'b1;  // this accepted cycle is the fifth fetch
    tick();
    halt_req = 1'b0;
    tick(); tick();
    n_checks++; if (fetch_count !== exp_f) begin n_fail++; $display("FAIL perf_fetch: got %0d want %0d", fetch_count, exp_f); end
    n_checks++; if (stall_count !== exp_s) begin n_fail++; $display("FAIL perf_stall: got %0d want %0d", stall_count, exp_s); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
